// File: rtl/sign_extend_arbiter_if.sv
// Handshake bundle between two immediate requesters, the shared sign-extend
// arbiter and its downstream consumer.
interface sign_extend_arbiter_if #(
    parameter int IN_BUS_WIDTH  = 12,
    parameter int OUT_BUS_WIDTH = 32
);
    logic                     req0_valid;
    logic [IN_BUS_WIDTH-1:0]  req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [IN_BUS_WIDTH-1:0]  req1_data;
    logic                     req1_ready;
    logic                     out_valid;
    logic [OUT_BUS_WIDTH-1:0] out_data;
    logic                     out_src;
    logic                     out_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/sign_extend_arbiter.sv
// Round-robin arbiter sharing one sign_extend between two requesters, with a
// one-entry tagged output buffer that refills in the same cycle it drains.
module sign_extend #(
    parameter int IN_BUS_WIDTH  = 12,
    parameter int OUT_BUS_WIDTH = 32
) (
    input  logic [IN_BUS_WIDTH-1:0]  in_data,
    output logic [OUT_BUS_WIDTH-1:0] out_data
);
    assign out_data = {{(OUT_BUS_WIDTH-IN_BUS_WIDTH){in_data[IN_BUS_WIDTH-1]}}, in_data};
endmodule

module sign_extend_arbiter #(
    parameter int IN_BUS_WIDTH  = 12,
    parameter int OUT_BUS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sign_extend_arbiter_if.slave  bus
);
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e               state_q, state_d;
    logic [OUT_BUS_WIDTH-1:0] out_data_q, out_data_d;
    logic                     out_src_q, out_src_d;
    logic                     last_grant_q, last_grant_d;

    logic                     can_accept;
    logic                     grant0, grant1;
    logic                     ready0, ready1;
    logic [IN_BUS_WIDTH-1:0]  sel_data;
    logic [OUT_BUS_WIDTH-1:0] ext_data;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        can_accept = (state_q == BUF_EMPTY) || bus.out_ready;
        grant0     = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1     = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        ready0     = grant0 && can_accept;
        ready1     = grant1 && can_accept;
        sel_data   = ready1 ? bus.req1_data : bus.req0_data;
    end

    sign_extend #(
        .IN_BUS_WIDTH  (IN_BUS_WIDTH),
        .OUT_BUS_WIDTH (OUT_BUS_WIDTH)
    ) u_sign_extend (
        .in_data  (sel_data),
        .out_data (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (ready0 || ready1) begin
            state_d      = BUF_FULL;
            out_data_d   = ext_data;
            out_src_d    = ready1;
            last_grant_d = ready1;
        end else if ((state_q == BUF_FULL) && bus.out_ready) begin
            // Drained with nothing to refill: payload is kept, only valid drops.
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BUF_EMPTY;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = (state_q == BUF_FULL);
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
endmodule

// File: tb/tb_sign_extend_arbiter.sv
// Self-checking bench for sign_extend_arbiter: directed scenarios plus a
// randomized protocol-abiding run against a transaction-level model.
module tb_sign_extend_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sign_extend_arbiter_if #(.IN_BUS_WIDTH(12), .OUT_BUS_WIDTH(32)) bus ();

    sign_extend_arbiter #(.IN_BUS_WIDTH(12), .OUT_BUS_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: buffer contents, fairness pointer, expected readies.
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_src;
    logic        m_last;
    logic        e_r0, e_r1;

    function automatic logic [31:0] sext(input logic [11:0] d);
        longint v;
        v = longint'(d);
        if (v >= 2048) v = v - 4096;
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        e_r0 = 1'b0; e_r1 = 1'b0;
    endtask

    task automatic model_ready();
        bit room;
        room = !m_valid || bus.out_ready;
        e_r0 = 1'b0; e_r1 = 1'b0;
        if (room) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
            end else if (bus.req0_valid) e_r0 = 1'b1;
            else if (bus.req1_valid) e_r1 = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (e_r0) begin
            m_valid = 1'b1; m_data = sext(bus.req0_data); m_src = 1'b0; m_last = 1'b0;
        end else if (e_r1) begin
            m_valid = 1'b1; m_data = sext(bus.req1_data); m_src = 1'b1; m_last = 1'b1;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic v0, input logic [11:0] d0,
                         input logic v1, input logic [11:0] d1, input logic ordy);
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_data = d1;
        bus.out_ready  = ordy;
        #1;
        model_ready();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_data = '0;
        bus.out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
        checks++; if (bus.out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src: got %b want 0", bus.out_src); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        $display("test_reset done");
    endtask

    task automatic test_positive();
        drive(1, 12'h2AA, 0, 12'h000, 1);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL pos_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pos_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h000002AA) begin errors++; $display("FAIL pos_data: got %h want 000002aa", bus.out_data); end
        checks++; if (bus.out_src !== 1'b0) begin errors++; $display("FAIL pos_src: got %b want 0", bus.out_src); end
        $display("test_positive: 2aa -> %h src %b", bus.out_data, bus.out_src);
    endtask

    task automatic test_negative();
        logic [11:0] din [3];
        logic [31:0] want [3];
        din[0] = 12'h87F; want[0] = 32'hFFFFF87F;
        din[1] = 12'h800; want[1] = 32'hFFFFF800;
        din[2] = 12'h7FF; want[2] = 32'h000007FF;
        for (int i = 0; i < 3; i++) begin
            drive(0, 12'h000, 1, din[i], 1);
            checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL neg_ready[%0d]: got %b%b want 01", i, bus.req0_ready, bus.req1_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== want[i] || bus.out_src !== 1'b1)
                begin errors++; $display("FAIL neg_out[%0d]: got v%b %h src%b want v1 %h src1", i, bus.out_valid, bus.out_data, bus.out_src, want[i]); end
            $display("test_negative: %h -> %h src %b", din[i], bus.out_data, bus.out_src);
        end
    endtask

    task automatic test_contention();
        logic [11:0] d0, d1;
        logic [31:0] want;
        for (int i = 0; i < 4; i++) begin
            d0 = 12'($urandom); d1 = 12'($urandom);
            drive(1, d0, 1, d1, 1);
            checks++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1))
                begin errors++; $display("FAIL cont_ready[%0d]: got %b%b want one-hot grant %0d", i, bus.req0_ready, bus.req1_ready, i % 2); end
            want = (i % 2 == 0) ? sext(d0) : sext(d1);
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_src !== 1'((i % 2)) || bus.out_data !== want)
                begin errors++; $display("FAIL cont_out[%0d]: got v%b %h src%b want v1 %h src%0d", i, bus.out_valid, bus.out_data, bus.out_src, want, i % 2); end
            $display("test_contention: cycle %0d grant src %b data %h", i, bus.out_src, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        drive(0, 12'h000, 1, 12'h87F, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 12'h123, 0, 12'h000, 0);
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, bus.req0_ready, bus.req1_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFF87F || bus.out_src !== 1'b1)
                begin errors++; $display("FAIL bp_hold[%0d]: got v%b %h src%b want v1 fffff87f src1", i, bus.out_valid, bus.out_data, bus.out_src); end
            $display("test_backpressure: stall %0d out %h", i, bus.out_data);
        end
        drive(1, 12'h123, 0, 12'h000, 1);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_ready: got %b want 1", bus.req0_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000123 || bus.out_src !== 1'b0)
            begin errors++; $display("FAIL bp_refill: got v%b %h src%b want v1 00000123 src0", bus.out_valid, bus.out_data, bus.out_src); end
        $display("test_backpressure: refill out %h", bus.out_data);
    endtask

    task automatic test_drain();
        drive(0, 12'h000, 0, 12'h000, 1);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h00000123) begin errors++; $display("FAIL drain_hold: got %h want 00000123", bus.out_data); end
        $display("test_drain: out_valid %b", bus.out_valid);
    endtask

    task automatic test_reset_mid();
        drive(1, 12'h055, 0, 12'h000, 0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_src !== 1'b0) begin errors++; $display("FAIL mid_setup: got v%b src%b want v1 src0", bus.out_valid, bus.out_src); end
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL mid_async_data: got %h want 00000000", bus.out_data); end
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1, 12'h9A0, 1, 12'h111, 1);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL mid_first_grant: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
        tick();
        checks++; if (bus.out_data !== 32'hFFFFF9A0 || bus.out_src !== 1'b0) begin errors++; $display("FAIL mid_first_out: got %h src%b want fffff9a0 src0", bus.out_data, bus.out_src); end
        $display("test_reset_mid: first grant src %b", bus.out_src);
    endtask

    task automatic test_random();
        logic        p0, p1;
        logic [11:0] pd0, pd1;
        int          acc;
        p0 = 0; p1 = 0; pd0 = '0; pd1 = '0; acc = 0;
        for (int i = 0; i < 300; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; pd0 = 12'($urandom); end
            if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; pd1 = 12'($urandom); end
            drive(p0, pd0, p1, pd1, $urandom_range(0, 3) != 0);
            checks++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1)
                begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, bus.req0_ready, bus.req1_ready, e_r0, e_r1); end
            tick();
            if (e_r0) p0 = 0;
            if (e_r1) p1 = 0;
            if (e_r0 || e_r1) acc++;
            checks++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_src !== m_src)
                begin errors++; $display("FAIL rnd_out[%0d]: got v%b %h src%b want v%b %h src%b", i, bus.out_valid, bus.out_data, bus.out_src, m_valid, m_data, m_src); end
        end
        $display("test_random: 300 cycles, %0d accepts", acc);
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_contention();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sign_extend_arbiter.md
# sign_extend_arbiter

Shares one `sign_extend` instance between two immediate requesters, for example the decode stage and the branch/AGU path. Each requester presents a narrow immediate over a valid/ready handshake. The arbiter picks one request per cycle using round-robin priority, sign-extends it, and registers the result in a one-entry output buffer tagged with the source ID. The block sits between the requesters and any consumer that can apply backpressure.

## Interface
- `IN_BUS_WIDTH`, default 12: width of each requester's immediate.
- `OUT_BUS_WIDTH`, default 32: width of the extended result. Must be greater than `IN_BUS_WIDTH`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an immediate.
- `req0_data`  in  IN_BUS_WIDTH  requester 0 immediate.
- `req0_ready`  out  1  requester 0 transfer accepted this cycle.
- `req1_valid`  in  1  requester 1 has an immediate.
- `req1_data`  in  IN_BUS_WIDTH  requester 1 immediate.
- `req1_ready`  out  1  requester 1 transfer accepted this cycle.
- `out_valid`  out  1  output buffer holds a result.
- `out_data`  out  OUT_BUS_WIDTH  sign-extended result.
- `out_src`  out  1  requester ID (0 or 1) that produced `out_data`.
- `out_ready`  in  1  consumer accepts the output this cycle.

## Operation
- Internal state:
  - Output buffer: `out_valid`, `out_data`, `out_src`.
  - Priority pointer `last_grant` (1 bit).
- Buffer states:
  - EMPTY (`out_valid`=0): any valid request is accepted.
  - FULL (`out_valid`=1): a request is accepted only if `out_ready`=1 in the same cycle (pass-through refill).
- `can_accept` = !`out_valid` || `out_ready`.
- Grant, combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
  - Neither valid: no grant.
- `reqN_ready` = grant_N && `can_accept`.
  - `reqN_ready` is 0 for a requester that is not valid.
  - At most one ready is high in any cycle.
- On accept (valid && ready for requester N):
  - `out_data` is loaded with the extended `reqN_data`: bits [IN_BUS_WIDTH-1:0] copied, upper bits replicate bit IN_BUS_WIDTH-1.
  - `out_src` loads N.
  - `out_valid` loads 1.
  - `last_grant` loads N.
- Consumption without accept (`out_valid` && `out_ready` && no accept): `out_valid` loads 0. `out_data` and `out_src` hold their last values.
- Simultaneous consume and accept: the buffer is overwritten with the new result and `out_valid` stays 1. No bubble.
- FULL && !`out_ready`:
  - Buffer holds. Both readies are 0.
  - Requesters must hold valid and data stable until accepted.
  - `last_grant` does not change.
- Extension uses the existing `sign_extend` block, instantiated with the module parameters. There is no arithmetic beyond replication.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `last_grant`=1 (so requester 0 wins the first contention).
- Reset is asynchronous. Assertion clears state immediately, including mid-transfer. A buffered, unconsumed result is discarded.
- `reqN_ready` is combinational from `reqN_valid`, `out_valid`, `out_ready` and `last_grant`. There is no combinational path from `reqN_data` to any output.
- Latency: accept at edge k, then `out_valid`=1 with the result visible after edge k (cycle k+1).
- Throughput: one result per cycle while `out_ready`=1.
- Fairness: under continuous contention the grants alternate 0,1,0,1. A requester never waits more than one accepted transfer of the other.
- `out_data` and `out_src` remain stable while `out_valid`=1 && `out_ready`=0.

## Test plan
- Reset and single positive request:
  - Stimulus: assert `rst`, release, then `req0_data`=12'h2AA, `out_ready`=1.
  - Required: `req0_ready`=1 that cycle; next cycle `out_valid`=1, `out_data`=32'h000002AA, `out_src`=0.
- Negative values from requester 1:
  - Stimulus: 12'h87F, then 12'h800.
  - Required: 32'hFFFFF87F, then 32'hFFFFF800, both with `out_src`=1.
  - Also check 12'h7FF gives 32'h000007FF.
- Contention:
  - Stimulus: both valid for 4 cycles, `out_ready`=1.
  - Required: grant order 0,1,0,1; exactly one ready per cycle; 4 back-to-back `out_valid` cycles.
- Backpressure:
  - Stimulus: buffer FULL with 32'hFFFFF87F, `out_ready`=0 for 3 cycles while `req0_valid`=1.
  - Required: both readies 0; `out_data` stable; when `out_ready`=1, same-cycle refill, `out_valid` stays 1.
- Drain:
  - Stimulus: one result, then no requests, `out_ready`=1.
  - Required: `out_valid` drops to 0 after one cycle.
- Reset mid-operation:
  - Stimulus: `out_valid`=1 with `last_grant`=0, assert `rst` asynchronously between edges.
  - Required: `out_valid` goes to 0 immediately; after release, contention grants requester 0 first.
